// File: rtl/xpb_gen_pkg.sv
// Shared types and defaults for the XPB reduction-table generator.
package xpb_gen_pkg;

  typedef enum logic [1:0] {IDLE, POW, EMIT, FIN} state_t;

  localparam int DEF_WIDTH = 1024;
  localparam int DEF_DIGIT = 5;
  localparam int DEF_SHIFT = 390;

  function automatic int unsigned entry_count(input int unsigned digit);
    return 32'd1 << digit;
  endfunction

endpackage

// File: rtl/mod_add_reduce.sv
// Combinational (a + b) mod m for operands already reduced below m.
module mod_add_reduce #(
  parameter int W = 8
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic [W-1:0] i_m,
  output logic [W-1:0] o_y
);

  logic [W:0]   w_sum;
  logic [W-1:0] w_diff;

  assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
  // True difference is below 2^W whenever it is selected, so W bits suffice.
  assign w_diff = w_sum[W-1:0] - i_m;
  assign o_y    = (w_sum >= {1'b0, i_m}) ? w_diff : w_sum[W-1:0];

endmodule

// File: rtl/xpb_table_gen.sv
// Builds the k * 2^SHIFT mod M table at runtime and streams it out over a
// valid/ready write port, one entry per accepted handshake.
module xpb_table_gen
  import xpb_gen_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIGIT = DEF_DIGIT,
  parameter int SHIFT = DEF_SHIFT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] modulus,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             wr_valid,
  input  logic             wr_ready,
  output logic [DIGIT-1:0] wr_addr,
  output logic [WIDTH-1:0] wr_data
);

  localparam int CW = (SHIFT > 1) ? $clog2(SHIFT) : 1;
  localparam logic [DIGIT-1:0] LAST     = DIGIT'(entry_count(DIGIT) - 32'd1);
  localparam logic [CW-1:0]    POW_LAST = CW'((SHIFT > 0) ? SHIFT - 1 : 0);

  state_t           r_state;
  logic [WIDTH-1:0] r_m;
  logic [WIDTH-1:0] r_acc;
  logic [CW-1:0]    r_cnt;
  logic             r_err;

  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_sum;

  // One adder serves both phases: doubling acc in POW, data + base in EMIT.
  // After POW, r_acc holds the base and is left untouched.
  assign w_a = (r_state == EMIT) ? wr_data : r_acc;

  mod_add_reduce #(.W(WIDTH)) u_add (
    .i_a (w_a),
    .i_b (r_acc),
    .i_m (r_m),
    .o_y (w_sum)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_m      <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_err    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_m     <= modulus;
            r_acc   <= WIDTH'(1);
            r_cnt   <= '0;
            busy    <= 1'b1;
            wr_addr <= '0;
            wr_data <= '0;
            if (modulus < WIDTH'(2)) begin
              r_err   <= 1'b1;
              r_state <= FIN;
            end else begin
              r_err <= 1'b0;
              if (SHIFT == 0) begin
                wr_valid <= 1'b1;
                r_state  <= EMIT;
              end else begin
                r_state <= POW;
              end
            end
          end
        end
        POW: begin
          r_acc <= w_sum;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == POW_LAST) begin
            wr_addr  <= '0;
            wr_data  <= '0;
            wr_valid <= 1'b1;
            r_state  <= EMIT;
          end
        end
        EMIT: begin
          if (wr_ready) begin
            if (wr_addr == LAST) begin
              wr_valid <= 1'b0;
              r_state  <= FIN;
            end else begin
              wr_addr <= wr_addr + 1'b1;
              wr_data <= w_sum;
            end
          end
        end
        FIN: begin
          done    <= 1'b1;
          err     <= r_err;
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xpb_table_gen.sv
// Randomized bench for xpb_table_gen across three configurations, checked
// against a bignum model of k * 2^SHIFT mod M.
module tb_xpb_table_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [2:0]          st, rdy;
  logic [2:0][1023:0]  md;
  logic [2:0]          ob, odn, oe, ov;
  logic [2:0][4:0]     oa;
  logic [2:0][1023:0]  od;

  logic [2:0]    a0;
  logic [7:0]    d0;
  logic [4:0]    a1;
  logic [15:0]   d1;
  logic [4:0]    a2;
  logic [1023:0] d2;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  xpb_table_gen #(.WIDTH(8), .DIGIT(3), .SHIFT(4)) u0 (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .modulus(md[0][7:0]),
    .busy(ob[0]), .done(odn[0]), .err(oe[0]), .wr_valid(ov[0]),
    .wr_ready(rdy[0]), .wr_addr(a0), .wr_data(d0));

  xpb_table_gen #(.WIDTH(16), .DIGIT(5), .SHIFT(16)) u1 (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .modulus(md[1][15:0]),
    .busy(ob[1]), .done(odn[1]), .err(oe[1]), .wr_valid(ov[1]),
    .wr_ready(rdy[1]), .wr_addr(a1), .wr_data(d1));

  xpb_table_gen u2 (
    .clk(clk), .rst_n(rst_n), .start(st[2]), .modulus(md[2]),
    .busy(ob[2]), .done(odn[2]), .err(oe[2]), .wr_valid(ov[2]),
    .wr_ready(rdy[2]), .wr_addr(a2), .wr_data(d2));

  assign oa[0] = {2'b0, a0};
  assign oa[1] = a1;
  assign oa[2] = a2;
  assign od[0] = {1016'b0, d0};
  assign od[1] = {1008'b0, d1};
  assign od[2] = d2;

  function automatic int wid(input int i);
    return (i == 0) ? 8 : (i == 1) ? 16 : 1024;
  endfunction
  function automatic int dig(input int i);
    return (i == 0) ? 3 : 5;
  endfunction
  function automatic int shf(input int i);
    return (i == 0) ? 4 : (i == 1) ? 16 : 390;
  endfunction

  task automatic chk(input string tag, input logic [1023:0] got, input logic [1023:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (low 192 bits) at %0t",
               tag, got[191:0], exp[191:0], $time);
    end
  endtask

  function automatic logic [1023:0] rand_wide();
    logic [1023:0] v;
    for (int w = 0; w < 32; w++) v[w*32 +: 32] = $urandom;
    return v;
  endfunction

  // pct: wr_ready probability; pulse: spray start while busy; abort_at: reset at that addr
  task automatic run(input int idx, input logic [1023:0] m, input int pct,
                     input bit pulse, input int abort_at);
    int            n = 1 << dig(idx);
    int            nexp = 0;
    int            last_hs = 0;
    int            first = -1;
    bit            finished = 0;
    bit            e;
    logic [1023:0] mm;
    logic [2047:0] m2, base, ex;
    mm = m & ((1024'b1 << wid(idx)) - 1024'b1);
    e = (mm < 1024'd2);
    m2 = {1024'b0, mm};
    base = '0;
    if (!e) base = (2048'b1 << shf(idx)) % m2;
    @(negedge clk);
    st[idx] = 1'b1;
    md[idx] = m;
    rdy[idx] = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (c == 0) begin
        st[idx] = 1'b0;
        md[idx] = rand_wide();
        chk("busy_after_start", {1023'b0, ob[idx]}, 1024'd1);
      end
      if (abort_at >= 0 && ov[idx] && nexp == abort_at) begin
        rst_n = 1'b0;
        rdy[idx] = 1'b0;
        @(negedge clk);
        chk("rst_vld", {1023'b0, ov[idx]}, 1024'd0);
        chk("rst_busy", {1023'b0, ob[idx]}, 1024'd0);
        chk("rst_addr", {1019'b0, oa[idx]}, 1024'd0);
        chk("rst_data", od[idx], 1024'd0);
        rst_n = 1'b1;
        for (int j = 0; j < 4; j++) begin
          @(negedge clk);
          chk("rst_no_done", {1023'b0, odn[idx] | ov[idx]}, 1024'd0);
        end
        finished = 1;
        break;
      end
      if (ov[idx]) begin
        if (first < 0) begin
          first = c;
          if (e) chk("err_wr_valid", 1024'd1, 1024'd0);
          else chk("first_valid_cycle", 1024'(c), 1024'(shf(idx)));
        end
        ex = (base * 2048'(nexp)) % m2;
        chk("addr", {1019'b0, oa[idx]}, 1024'(nexp));
        chk("data", od[idx], ex[1023:0]);
      end
      if (odn[idx]) begin
        chk("err_flag", {1023'b0, oe[idx]}, {1023'b0, e});
        chk("entry_count", 1024'(nexp), e ? 1024'd0 : 1024'(n));
        chk("done_cycle", 1024'(c), e ? 1024'd1 : 1024'(last_hs + 1));
        finished = 1;
        break;
      end
      rdy[idx] = ($urandom_range(99) < pct);
      if (ov[idx] && rdy[idx]) begin
        nexp++;
        last_hs = c + 1;
      end
      st[idx] = pulse && ob[idx] && ($urandom_range(3) == 0);
    end
    st[idx] = 1'b0;
    rdy[idx] = 1'b0;
    if (!finished) chk("timeout", 1024'd0, 1024'd1);
    @(negedge clk);
    chk("idle_after", {1022'b0, ob[idx], odn[idx]}, 1024'd0);
  endtask

  initial begin
    logic [1023:0] big;
    st = '0;
    rdy = '0;
    md = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("reset_ctl", {1020'b0, ob[i], odn[i], oe[i], ov[i]}, 1024'd0);
      chk("reset_addr", {1019'b0, oa[i]}, 1024'd0);
      chk("reset_data", od[i], 1024'd0);
    end
    rst_n = 1'b1;

    run(0, 1024'd13, 100, 0, -1);
    run(0, 1024'd1, 100, 0, -1);
    run(0, 1024'd0, 100, 0, -1);
    for (int r = 0; r < 3; r++) run(0, 1024'($urandom_range(255, 2)), 60, 1, -1);

    run(1, 1024'd65521, 100, 0, -1);
    run(1, 1024'd65521, 50, 0, -1);
    run(1, 1024'd65521, 100, 0, 10);
    run(1, 1024'd65521, 100, 0, -1);
    run(1, 1024'd1, 50, 0, -1);
    for (int r = 0; r < 3; r++) run(1, 1024'($urandom_range(65535, 2)), 50, 1, -1);

    big = rand_wide();
    big[1023] = 1'b1;
    big[0] = 1'b1;
    run(2, big, 100, 1, -1);
    big = rand_wide();
    big[1023] = 1'b1;
    big[0] = 1'b1;
    run(2, big, 70, 1, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
